// File: rtl/cv32e40p_rvfi_pkg.sv
// cv32e40p_rvfi_pkg: shared types and constants for the RVFI retire buffer
package cv32e40p_rvfi_pkg;
  localparam int MASK_W = 4;
  typedef struct packed {
    logic              valid;
    logic              complete;
    logic [31:0]       insn;
    logic [31:0]       pc;
    logic              trap;
    logic [4:0]        rd_addr;
    logic [31:0]       rd_wdata;
    logic [31:0]       mem_addr;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       start_cycle;
  } rvfi_retire_entry_t;
endpackage

// File: rtl/cv32e40p_rvfi_retire_buffer.sv
// cv32e40p_rvfi_retire_buffer: in-order buffer that retires one complete RVFI packet per cycle; issue_* in, wb_* late data, rvfi_* registered packet out
module cv32e40p_rvfi_retire_buffer
  import cv32e40p_rvfi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  output logic [TAG_W-1:0]  issue_tag_o,
  input  logic [31:0]       issue_insn_i,
  input  logic [31:0]       issue_pc_i,
  input  logic              issue_trap_i,
  input  logic [4:0]        issue_rd_addr_i,
  input  logic [31:0]       issue_rd_wdata_i,
  input  logic              issue_wb_pending_i,
  input  logic [31:0]       issue_mem_addr_i,
  input  logic [MASK_W-1:0] issue_mem_rmask_i,
  input  logic [MASK_W-1:0] issue_mem_wmask_i,
  input  logic [31:0]       issue_mem_wdata_i,
  input  logic              wb_valid_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  input  logic [31:0]       wb_rdata_i,
  input  logic              flush_i,
  output logic              rvfi_valid_o,
  output logic [63:0]       rvfi_order_o,
  output logic [31:0]       rvfi_insn_o,
  output logic [31:0]       rvfi_pc_rdata_o,
  output logic              rvfi_trap_o,
  output logic [4:0]        rvfi_rd_addr_o,
  output logic [31:0]       rvfi_rd_wdata_o,
  output logic [31:0]       rvfi_mem_addr_o,
  output logic [31:0]       rvfi_mem_rdata_o,
  output logic [31:0]       rvfi_mem_wdata_o,
  output logic [MASK_W-1:0] rvfi_mem_rmask_o,
  output logic [MASK_W-1:0] rvfi_mem_wmask_o,
  output logic [31:0]       rvfi_start_cycle_o,
  output logic [31:0]       rvfi_stop_cycle_o
);
  rvfi_retire_entry_t r_ent [DEPTH];
  rvfi_retire_entry_t w_head;
  logic [TAG_W-1:0]   r_wp, r_rp;
  logic [TAG_W:0]     r_cnt;
  logic [31:0]        r_cyc;
  logic [63:0]        r_order;
  logic               w_accept, w_retire, w_wb;
  logic               r_valid, r_trap;
  logic [63:0]        r_pkt_order;
  logic [31:0]        r_insn, r_pc, r_rd_wdata, r_mem_addr, r_mem_rdata, r_mem_wdata, r_start, r_stop;
  logic [4:0]         r_rd_addr;
  logic [MASK_W-1:0]  r_rmask, r_wmask;
  assign w_head = r_ent[r_rp];
  // cnt never exceeds DEPTH (a power of two), so its MSB alone flags full
  assign issue_ready_o = !r_cnt[TAG_W] && !flush_i;
  assign issue_tag_o   = r_wp;
  assign w_accept = issue_valid_i && issue_ready_o;
  assign w_retire = w_head.valid && w_head.complete && !flush_i;
  assign w_wb     = wb_valid_i && !flush_i && r_ent[wb_tag_i].valid && !r_ent[wb_tag_i].complete;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ent       <= '{default: '0};
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_cyc       <= '0;
      r_order     <= '0;
      r_valid     <= 1'b0;
      r_pkt_order <= '0;
      r_insn      <= '0;
      r_pc        <= '0;
      r_trap      <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_wdata  <= '0;
      r_mem_addr  <= '0;
      r_mem_rdata <= '0;
      r_mem_wdata <= '0;
      r_rmask     <= '0;
      r_wmask     <= '0;
      r_start     <= '0;
      r_stop      <= '0;
    end else begin
      r_cyc   <= r_cyc + 32'd1;
      r_valid <= w_retire;
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_accept) begin
          r_ent[r_wp] <= '{valid: 1'b1, complete: !issue_wb_pending_i, insn: issue_insn_i,
                           pc: issue_pc_i, trap: issue_trap_i, rd_addr: issue_rd_addr_i,
                           rd_wdata: issue_rd_wdata_i, mem_addr: issue_mem_addr_i,
                           mem_rmask: issue_mem_rmask_i, mem_wmask: issue_mem_wmask_i,
                           mem_wdata: issue_mem_wdata_i, mem_rdata: '0, start_cycle: r_cyc};
          r_wp <= r_wp + 1'b1;
        end
        // wb only targets a pending entry, so it never collides with accept or retire indices
        if (w_wb) begin
          r_ent[wb_tag_i].rd_wdata  <= wb_rdata_i;
          r_ent[wb_tag_i].mem_rdata <= wb_rdata_i;
          r_ent[wb_tag_i].complete  <= 1'b1;
        end
        if (w_retire) begin
          r_ent[r_rp] <= '0;
          r_rp        <= r_rp + 1'b1;
          r_order     <= r_order + 64'd1;
          r_pkt_order <= r_order;
          r_insn      <= w_head.insn;
          r_pc        <= w_head.pc;
          r_trap      <= w_head.trap;
          r_rd_addr   <= w_head.rd_addr;
          r_rd_wdata  <= (w_head.rd_addr == 5'd0) ? 32'd0 : w_head.rd_wdata;
          r_mem_addr  <= w_head.mem_addr;
          r_mem_rdata <= w_head.mem_rdata;
          r_mem_wdata <= w_head.mem_wdata;
          r_rmask     <= w_head.mem_rmask;
          r_wmask     <= w_head.mem_wmask;
          r_start     <= w_head.start_cycle;
          r_stop      <= r_cyc;
        end
        r_cnt <= r_cnt + (TAG_W+1)'(w_accept) - (TAG_W+1)'(w_retire);
      end
    end
  end
  assign rvfi_valid_o       = r_valid;
  assign rvfi_order_o       = r_pkt_order;
  assign rvfi_insn_o        = r_insn;
  assign rvfi_pc_rdata_o    = r_pc;
  assign rvfi_trap_o        = r_trap;
  assign rvfi_rd_addr_o     = r_rd_addr;
  assign rvfi_rd_wdata_o    = r_rd_wdata;
  assign rvfi_mem_addr_o    = r_mem_addr;
  assign rvfi_mem_rdata_o   = r_mem_rdata;
  assign rvfi_mem_wdata_o   = r_mem_wdata;
  assign rvfi_mem_rmask_o   = r_rmask;
  assign rvfi_mem_wmask_o   = r_wmask;
  assign rvfi_start_cycle_o = r_start;
  assign rvfi_stop_cycle_o  = r_stop;
endmodule

// File: tb/tb_cv32e40p_rvfi_retire_buffer.sv
// tb_cv32e40p_rvfi_retire_buffer: random and directed stimulus against a queue-based retirement model
module tb_cv32e40p_rvfi_retire_buffer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic issue_valid_i = 0, issue_ready_o, issue_trap_i = 0, issue_wb_pending_i = 0;
  logic [TAG_W-1:0] issue_tag_o, wb_tag_i = '0;
  logic [31:0] issue_insn_i = '0, issue_pc_i = '0, issue_rd_wdata_i = '0, issue_mem_addr_i = '0, issue_mem_wdata_i = '0;
  logic [4:0] issue_rd_addr_i = '0;
  logic [3:0] issue_mem_rmask_i = '0, issue_mem_wmask_i = '0;
  logic wb_valid_i = 0, flush_i = 0;
  logic [31:0] wb_rdata_i = '0;
  logic rvfi_valid_o, rvfi_trap_o;
  logic [63:0] rvfi_order_o;
  logic [31:0] rvfi_insn_o, rvfi_pc_rdata_o, rvfi_rd_wdata_o, rvfi_mem_addr_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o;
  logic [31:0] rvfi_start_cycle_o, rvfi_stop_cycle_o;
  logic [4:0] rvfi_rd_addr_o;
  logic [3:0] rvfi_mem_rmask_o, rvfi_mem_wmask_o;
  always #5 clk = ~clk;
  cv32e40p_rvfi_retire_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_tag_o(issue_tag_o),
    .issue_insn_i(issue_insn_i), .issue_pc_i(issue_pc_i), .issue_trap_i(issue_trap_i),
    .issue_rd_addr_i(issue_rd_addr_i), .issue_rd_wdata_i(issue_rd_wdata_i),
    .issue_wb_pending_i(issue_wb_pending_i), .issue_mem_addr_i(issue_mem_addr_i),
    .issue_mem_rmask_i(issue_mem_rmask_i), .issue_mem_wmask_i(issue_mem_wmask_i),
    .issue_mem_wdata_i(issue_mem_wdata_i), .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i),
    .wb_rdata_i(wb_rdata_i), .flush_i(flush_i), .rvfi_valid_o(rvfi_valid_o),
    .rvfi_order_o(rvfi_order_o), .rvfi_insn_o(rvfi_insn_o), .rvfi_pc_rdata_o(rvfi_pc_rdata_o),
    .rvfi_trap_o(rvfi_trap_o), .rvfi_rd_addr_o(rvfi_rd_addr_o), .rvfi_rd_wdata_o(rvfi_rd_wdata_o),
    .rvfi_mem_addr_o(rvfi_mem_addr_o), .rvfi_mem_rdata_o(rvfi_mem_rdata_o),
    .rvfi_mem_wdata_o(rvfi_mem_wdata_o), .rvfi_mem_rmask_o(rvfi_mem_rmask_o),
    .rvfi_mem_wmask_o(rvfi_mem_wmask_o), .rvfi_start_cycle_o(rvfi_start_cycle_o),
    .rvfi_stop_cycle_o(rvfi_stop_cycle_o)
  );
  typedef struct {
    int tag;
    bit cmp;
    logic [31:0] insn, pc, rdw, maddr, mwd, mrd, st;
    logic trap;
    logic [4:0] rd;
    logic [3:0] rm, wm;
  } ent_t;
  ent_t q[$];
  int m_wp;
  longint unsigned m_order;
  logic [31:0] m_cyc;
  int n_tot = 0, n_bad = 0;
  int pi[$];
  bit rwv;
  int rwt;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    issue_valid_i = 0;
    wb_valid_i = 0;
    flush_i = 0;
    #2 rst_ni = 0;
    #1;
    chk("rst_valid", rvfi_valid_o, 0);
    chk("rst_order", rvfi_order_o, 0);
    chk("rst_pc", rvfi_pc_rdata_o, 0);
    chk("rst_rdw", rvfi_rd_wdata_o, 0);
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_tag", issue_tag_o, 0);
    q.delete();
    m_wp = 0;
    m_order = 0;
    m_cyc = 0;
    @(negedge clk);
    rst_ni = 1;
  endtask
  task automatic step(input bit iv, input bit pend, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [31:0] pc, input bit wbv, input int wbt, input logic [31:0] wbd, input bit fl);
    ent_t e, r;
    bit rdy, ev;
    longint unsigned eo;
    logic [31:0] es;
    issue_valid_i = iv;
    issue_wb_pending_i = pend;
    issue_rd_addr_i = rd;
    issue_rd_wdata_i = wd;
    issue_pc_i = pc;
    issue_insn_i = $urandom;
    issue_trap_i = 1'($urandom_range(1));
    issue_mem_addr_i = $urandom;
    issue_mem_rmask_i = 4'($urandom);
    issue_mem_wmask_i = 4'($urandom);
    issue_mem_wdata_i = $urandom;
    wb_valid_i = wbv;
    wb_tag_i = TAG_W'(wbt);
    wb_rdata_i = wbd;
    flush_i = fl;
    #1;
    rdy = (q.size() < DEPTH) && !fl;
    chk("ready", issue_ready_o, rdy);
    chk("tag", issue_tag_o, 64'(m_wp));
    ev = 0;
    eo = 0;
    es = 0;
    if (!fl && q.size() > 0 && q[0].cmp) begin
      ev = 1;
      r = q.pop_front();
      eo = m_order;
      es = m_cyc;
      m_order++;
    end
    if (fl) begin
      q.delete();
      m_wp = 0;
    end else begin
      if (wbv)
        foreach (q[i])
          if (q[i].tag == wbt && !q[i].cmp) begin
            q[i].rdw = wbd;
            q[i].mrd = wbd;
            q[i].cmp = 1;
          end
      if (iv && rdy) begin
        e.tag = m_wp; e.cmp = !pend; e.insn = issue_insn_i; e.pc = pc; e.trap = issue_trap_i;
        e.rd = rd; e.rdw = wd; e.maddr = issue_mem_addr_i; e.rm = issue_mem_rmask_i;
        e.wm = issue_mem_wmask_i; e.mwd = issue_mem_wdata_i; e.mrd = 0; e.st = m_cyc;
        q.push_back(e);
        m_wp = (m_wp + 1) % DEPTH;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
    chk("valid", rvfi_valid_o, ev);
    if (ev) begin
      chk("order", rvfi_order_o, eo);
      chk("insn", rvfi_insn_o, r.insn);
      chk("pc", rvfi_pc_rdata_o, r.pc);
      chk("trap", rvfi_trap_o, r.trap);
      chk("rd_addr", rvfi_rd_addr_o, r.rd);
      chk("rd_wdata", rvfi_rd_wdata_o, (r.rd == 0) ? 32'd0 : r.rdw);
      chk("mem_addr", rvfi_mem_addr_o, r.maddr);
      chk("mem_rdata", rvfi_mem_rdata_o, r.mrd);
      chk("mem_wdata", rvfi_mem_wdata_o, r.mwd);
      chk("rmask", rvfi_mem_rmask_o, r.rm);
      chk("wmask", rvfi_mem_wmask_o, r.wm);
      chk("start", rvfi_start_cycle_o, r.st);
      chk("stop", rvfi_stop_cycle_o, es);
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    idle(3);
    step(1, 0, 5, 32'h7, 32'h80, 0, 0, 0, 0);
    idle(1);
    chk("t1_start", rvfi_start_cycle_o, 3);
    chk("t1_stop", rvfi_stop_cycle_o, 4);
    chk("t1_order", rvfi_order_o, 0);
    chk("t1_rdw", rvfi_rd_wdata_o, 32'h7);
    idle(2);
    do_reset();
    step(1, 1, 7, 0, 32'h100, 0, 0, 0, 0);
    step(1, 0, 8, 32'h11, 32'h104, 0, 0, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    idle(1);
    chk("ooo_rdw", rvfi_rd_wdata_o, 32'hDEADBEEF);
    chk("ooo_mrd", rvfi_mem_rdata_o, 32'hDEADBEEF);
    chk("ooo_order0", rvfi_order_o, 0);
    idle(1);
    chk("ooo_order1", rvfi_order_o, 1);
    chk("ooo_pc1", rvfi_pc_rdata_o, 32'h104);
    idle(1);
    step(1, 0, 0, 32'h55, 32'h200, 0, 0, 0, 0);
    idle(1);
    chk("x0_rdw", rvfi_rd_wdata_o, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 1, 5'(i + 1), $urandom, 32'h300 + 32'(4 * i), 0, 0, 0, 0);
    step(1, 0, 3, 1, 32'h400, 1, q[0].tag, 32'h1234, 1);
    idle(2);
    step(1, 0, 9, 32'h99, 32'h500, 0, 0, 0, 0);
    idle(1);
    chk("flush_order", rvfi_order_o, 3);
    for (int i = 0; i < 4; i++) step(1, 1, 5'(i + 1), $urandom, 32'h600 + 32'(4 * i), 0, 0, 0, 0);
    step(1, 0, 4, 4, 32'h700, 0, 0, 0, 0);
    step(1, 0, 4, 4, 32'h700, 1, q[0].tag, 32'hCAFE, 0);
    step(1, 0, 4, 4, 32'h700, 0, 0, 0, 0);
    step(1, 0, 4, 4, 32'h700, 0, 0, 0, 0);
    while (q.size() > 0 && !q[0].cmp) step(0, 0, 0, 0, 0, 1, q[0].tag, $urandom, 0);
    idle(4);
    for (int c = 0; c < 600; c++) begin
      pi = q.find_index with (!item.cmp);
      rwv = pi.size() > 0 && $urandom_range(1) == 1;
      rwt = rwv ? q[pi[$urandom_range(pi.size() - 1)]].tag : 0;
      step($urandom_range(2) != 0, 1'($urandom_range(1)), 5'($urandom), $urandom, $urandom,
           rwv, rwt, $urandom, $urandom_range(39) == 0);
    end
    step(1, 0, 6, 32'h66, 32'h800, 0, 0, 0, 1);
    step(1, 0, 6, 32'h66, 32'h800, 0, 0, 0, 0);
    step(1, 1, 6, 32'h66, 32'h804, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 10, 32'hA, 32'h900, 0, 0, 0, 0);
    idle(1);
    chk("arst_order", rvfi_order_o, 0);
    chk("arst_pc", rvfi_pc_rdata_o, 32'h900);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
